ioctl_mem_loader: RTL

Downstream consumer of the HPS file-download stream (ioctl_* outputs of the HPS I/O block).
- Buffers incoming download bytes in a small FIFO.
- Merges contiguous even/odd byte pairs into 16-bit word writes.
- Issues byte-enabled write requests to the core's 16-bit ROM/RAM arbiter.
- Drives ioctl_wait back to the HPS I/O block so downloads throttle when the memory side is slow.

---
 rtl/ioctl_mem_loader_if.sv | 30 +++
 rtl/ioctl_mem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ioctl_mem_loader_if.sv
// Bus bundle between the HPS download stream, the loader and the 16-bit memory arbiter.
// The loader is the memory-side master; the HPS I/O block and arbiter form the slave side.
interface ioctl_mem_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_be;
  logic        mem_req;
  logic        mem_ack;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait,
    output mem_addr, mem_din, mem_be, mem_req,
    input  mem_ack
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait,
    input  mem_addr, mem_din, mem_be, mem_req,
    output mem_ack
  );
endinterface

// File: rtl/ioctl_mem_loader.sv
// HPS download consumer: buffers ioctl bytes in a FIFO, merges even/odd pairs into
// byte-enabled 16-bit writes and throttles the download with ioctl_wait.
module ioctl_mem_loader #(
  parameter int FIFO_AW     = 3,
  parameter int WAIT_MARGIN = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  ioctl_mem_loader_if.master   bus,
  output logic                 load_busy,
  output logic                 load_done,
  output logic [7:0]           load_index,
  output logic [24:0]          byte_count,
  output logic                 overflow
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int PTR_W = FIFO_AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    REQ  = 2'd2
  } state_t;

  // FIFO storage: {addr[24:0], byte[7:0]}
  logic [32:0]      fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] fill_cnt;
  logic [PTR_W-1:0] fill_cnt_next;
  logic [PTR_W-1:0] free_slots;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             drop;
  logic [24:0]      head_addr;
  logic [7:0]       head_byte;

  state_t           state_reg;
  logic [24:0]      hold_addr_reg;
  logic [7:0]       hold_lo_reg;
  logic [23:0]      mem_addr_reg;
  logic [15:0]      mem_din_reg;
  logic [1:0]       mem_be_reg;
  logic             mem_req_reg;

  logic             wait_reg;
  logic             dl_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [7:0]       index_reg;
  logic [24:0]      count_reg;
  logic             overflow_reg;

  logic             dl_start;
  logic             busy_now;
  logic             pair_match;

  assign fill_cnt      = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty    = (fill_cnt == '0);
  assign fifo_full     = (fill_cnt == PTR_W'(DEPTH));
  assign free_slots    = PTR_W'(DEPTH) - fill_cnt;
  assign {head_addr, head_byte} = fifo_mem[rd_ptr_reg[FIFO_AW-1:0]];
  assign pair_match    = (head_addr == {hold_addr_reg[24:1], 1'b1});

  // Pop decision is shared by the FIFO pointers and the FSM so both see the same event.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      case (state_reg)
        IDLE:    pop = 1'b1;
        HOLD:    pop = pair_match;
        default: pop = 1'b0;
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a write into a full FIFO still lands.
  assign push          = bus.ioctl_wr & (~fifo_full | pop);
  assign drop          = bus.ioctl_wr & fifo_full & ~pop;
  assign fill_cnt_next = fill_cnt + PTR_W'(push) - PTR_W'(pop);
  assign dl_start      = bus.ioctl_download & ~dl_reg;
  assign busy_now      = bus.ioctl_download | ~fifo_empty | (state_reg != IDLE);

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[FIFO_AW-1:0]] <= {bus.ioctl_addr, bus.ioctl_dout};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      wait_reg     <= 1'b0;
      dl_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      index_reg    <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      // Deliberately one cycle late; the margin covers the write already in flight.
      wait_reg <= (fill_cnt_next != '0) && (free_slots <= PTR_W'(WAIT_MARGIN));
      dl_reg   <= bus.ioctl_download;
      busy_reg <= busy_now;
      done_reg <= busy_reg & ~busy_now;
      if (dl_start) begin
        index_reg    <= bus.ioctl_index;
        count_reg    <= {24'd0, push};
        overflow_reg <= drop;
      end else begin
        if (push) begin
          count_reg <= count_reg + 25'd1;
        end
        if (drop) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

  // Holding-register validity is implied by the HOLD state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      hold_addr_reg <= '0;
      hold_lo_reg   <= '0;
      mem_addr_reg  <= '0;
      mem_din_reg   <= '0;
      mem_be_reg    <= '0;
      mem_req_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            if (!head_addr[0]) begin
              hold_addr_reg <= head_addr;
              hold_lo_reg   <= head_byte;
              state_reg     <= HOLD;
            end else begin
              mem_addr_reg <= head_addr[24:1];
              mem_din_reg  <= {head_byte, 8'h00};
              mem_be_reg   <= 2'b10;
              mem_req_reg  <= 1'b1;
              state_reg    <= REQ;
            end
          end
        end
        HOLD: begin
          if (!fifo_empty && pair_match) begin
            mem_addr_reg <= hold_addr_reg[24:1];
            mem_din_reg  <= {head_byte, hold_lo_reg};
            mem_be_reg   <= 2'b11;
            mem_req_reg  <= 1'b1;
            state_reg    <= REQ;
          end else if (!fifo_empty || !bus.ioctl_download) begin
            // Unrelated next byte or end of download: write the even byte alone.
            mem_addr_reg <= hold_addr_reg[24:1];
            mem_din_reg  <= {8'h00, hold_lo_reg};
            mem_be_reg   <= 2'b01;
            mem_req_reg  <= 1'b1;
            state_reg    <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            mem_req_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          mem_req_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ioctl_wait = wait_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_din    = mem_din_reg;
  assign bus.mem_be     = mem_be_reg;
  assign bus.mem_req    = mem_req_reg;
  assign load_busy      = busy_reg;
  assign load_done      = done_reg;
  assign load_index     = index_reg;
  assign byte_count     = count_reg;
  assign overflow       = overflow_reg;

endmodule
